btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Input-conditioning stage directly upstream of the sprite display/game core. Takes the three raw, bouncy, asynchronous board buttons (btnC, btnL, btnR) and produces clean single-cycle command pulses: a start pulse from the centre button, and left/right steer steps with hold-to-auto-repeat. The game core consumes only these pulses and levels, never the raw buttons.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- REPEAT_DELAY, 25_000_000: cycles from accepted L/R press to first auto-repeat step.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat steps.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btnC / btnL / btnR  in  1 each  raw button inputs, asynchronous to clk.
- start_pulse  out  1  one-cycle pulse on accepted btnC press.
- left_step / right_step  out  1 each  one-cycle steer step pulses.
- left_held / right_held  out  1 each  debounced button levels.

## Operation
- Each button: 2-flop synchronizer, then debounce counter. Debounced level flips once the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle clears the counter to 0.
- start_pulse: asserted for exactly the one cycle in which debounced C rises. No repeat; release produces nothing.
- L/R channel FSM per side: IDLE -> (debounced rise) FIRST -> (REPEAT_DELAY elapsed) REPEAT -> (each REPEAT_PERIOD) REPEAT; any state -> IDLE on debounced fall.
- Step pulse emitted on entry to FIRST, on entry to REPEAT, and at each REPEAT_PERIOD expiry.
- Conflict rule: while left_held and right_held are both 1, both step outputs are 0 and both repeat counters held at 0. When one side releases, the surviving side re-enters FIRST without a pulse and waits a full REPEAT_DELAY before its next step.
- Both accepted in the same cycle: no pulse from either.
- left_step and right_step are never 1 in the same cycle.

## Timing
- Reset (async assert, sync-deassert handling not required inside block): all outputs 0, synchronizers, debounced levels, counters 0, FSMs IDLE. Reset asserted mid-hold clears immediately; a button still held at deassertion is accepted as a fresh press.
- Press latency: raw change stable before edge k -> pulse/level visible in cycle after edge k+2+DEBOUNCE_CYCLES−1, i.e. DEBOUNCE_CYCLES+2 cycles.
- Release latency identical.
- Repeat: first repeat pulse exactly REPEAT_DELAY cycles after the FIRST pulse; subsequent pulses exactly REPEAT_PERIOD apart.
- All outputs registered; no combinational path from buttons to outputs.
- Counter widths $clog2(param+1); counters saturate, never wrap.

## Structure
- Package btn_pkg: default parameter constants, channel FSM state enum (IDLE, FIRST, REPEAT).
- Sub-module btn_debounce (synchronizer + debounce counter, outputs level and rise strobe), instantiated three times; repeat FSMs and conflict logic in top.

## Test plan
Parameters for bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- rst_n low with btnL=1, release -> all outputs 0 during reset; left_step single pulse 6 cycles after release, left_held=1 from same cycle.
- btnL bounces (3 high, 1 low, ×5) then stays high -> no pulse during bounce; exactly one left_step 6 cycles after final rise.
- btnR held 30 cycles past acceptance t0 -> right_step at t0, t0+8, +12, +16, +20, +24, +28 (7 pulses); release -> right_held falls 6 cycles later, no further steps.
- btnL and btnR held together -> zero step pulses; release btnL -> left_held falls, right_step next fires 8 cycles after that.
- btnC held 50 cycles -> exactly one start_pulse, 6 cycles after press; no L/R activity.
- rst_n pulsed low mid-repeat on btnL -> outputs 0 asynchronously; after deassert, left_step again 6 cycles later, then repeat at +8.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and types for the button conditioner.
//   - Default timing parameters (cycles at 100 MHz).
//   - ch_state_t: per-side steer channel state (IDLE, FIRST, REPEAT).
//   - max_int: constant helper used to size the shared repeat counter.
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int DEF_REPEAT_DELAY    = 25_000_000; // 250 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000; // 100 ms

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } ch_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a debounce counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn         raw asynchronous button input
//   level       debounced level as it will be after the coming clock edge
//               (derived from flops only, never from btn directly)
//   rise        high in the cycle whose closing edge accepts a press
// The debounced level flips once the synchronized input has differed from
// it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle clears the
// counter. level/rise are "next-edge" views so that a downstream register
// can present the accepted level and its step pulse in the very cycle the
// debounced level changes, keeping the overall latency at DEBOUNCE_CYCLES+2.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          differ;
  logic          accept;

  assign differ = (sync2_reg != level_reg);
  // This cycle is the last of the required run of differing cycles.
  assign accept = differ && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (accept) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else if (cnt_reg != CNT_SAT) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg ^ accept;
  assign rise  = accept & ~level_reg;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns the three raw board buttons into clean commands.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   btnC, btnL, btnR         raw asynchronous buttons
//   start_pulse              one-cycle pulse when centre press is accepted
//   left_step, right_step    one-cycle steer steps with hold-to-repeat
//   left_held, right_held    debounced left/right levels
// Each steer side runs IDLE -> FIRST -> REPEAT. While both sides are held
// (or in the cycle one of them is released) both channels are parked in
// FIRST with a zero counter and no pulses, so the surviving side waits a
// full REPEAT_DELAY before stepping again.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnC,
  input  logic btnL,
  input  logic btnR,
  output logic start_pulse,
  output logic left_step,
  output logic right_step,
  output logic left_held,
  output logic right_held
);

  localparam int CNT_TOP = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_TOP);

  logic       c_level_unused;
  logic       c_rise;
  logic [1:0] lr_raw;
  logic [1:0] lr_level;
  logic [1:0] lr_rise;
  logic [1:0] held_reg;
  logic [1:0] step;
  logic       start_reg;
  logic       freeze;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btnC),
    .level (c_level_unused),
    .rise  (c_rise)
  );

  // Index 0 = left, 1 = right.
  assign lr_raw = {btnR, btnL};

  // Conflict: both held after this edge, or both held right now (covers
  // the release edge so the survivor restarts its delay from zero).
  assign freeze = (&lr_level) | (&held_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      ch_state_t     state_reg;
      ch_state_t     state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          step_reg;
      logic          step_next;

      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (lr_raw[gi]),
        .level (lr_level[gi]),
        .rise  (lr_rise[gi])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          step_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          step_reg  <= step_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        step_next  = 1'b0;
        if (!lr_level[gi]) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (freeze) begin
          state_next = FIRST;
          cnt_next   = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (lr_rise[gi]) begin
                state_next = FIRST;
                cnt_next   = '0;
                step_next  = 1'b1;
              end
            end
            FIRST: begin
              if (cnt_reg == DELAY_LAST) begin
                state_next = REPEAT;
                cnt_next   = '0;
                step_next  = 1'b1;
              end else if (cnt_reg != CNT_SAT) begin
                cnt_next = cnt_reg + CW'(1);
              end
            end
            REPEAT: begin
              if (cnt_reg == PERIOD_LAST) begin
                cnt_next  = '0;
                step_next = 1'b1;
              end else if (cnt_reg != CNT_SAT) begin
                cnt_next = cnt_reg + CW'(1);
              end
            end
            default: begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      assign step[gi] = step_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg  <= 2'b00;
      start_reg <= 1'b0;
    end else begin
      held_reg  <= lr_level;
      start_reg <= c_rise;
    end
  end

  assign start_pulse = start_reg;
  assign left_step   = step[0];
  assign right_step  = step[1];
  assign left_held   = held_reg[0];
  assign right_held  = held_reg[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4. Inputs change just after a falling edge; outputs are
// sampled on falling edges. Row/cycle t means "sampled after the t-th
// rising edge since the inputs were applied".
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btnC  = 1'b0;
  logic btnL  = 1'b0;
  logic btnR  = 1'b0;
  logic start_pulse, left_step, right_step, left_held, right_held;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnC       (btnC),
    .btnL       (btnL),
    .btnR       (btnR),
    .start_pulse(start_pulse),
    .left_step  (left_step),
    .right_step (right_step),
    .left_held  (left_held),
    .right_held (right_held)
  );

  always #5 clk = ~clk;

  // Table record: left input for the row, expected {start,lstep,rstep,lheld,rheld}.
  typedef struct {
    logic       l;
    logic [4:0] exp;
  } vec_t;

  vec_t tv[1:25];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   t;
  int   pt[3][16];   // pulse times per channel: 0=start, 1=left, 2=right
  int   pn[3];
  int   lfall, rfall;
  int   overlap = 0;
  logic prev_lh, prev_rh;

  function automatic logic [4:0] outs();
    return {start_pulse, left_step, right_step, left_held, right_held};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic rec(input int ch);
    if (pn[ch] < 16) pt[ch][pn[ch]] = t;
    pn[ch]++;
  endtask

  task automatic clear();
    t = 0;
    for (int c = 0; c < 3; c++) pn[c] = 0;
    lfall   = -1;
    rfall   = -1;
    prev_lh = left_held;
    prev_rh = right_held;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t++;
      if (start_pulse) rec(0);
      if (left_step)   rec(1);
      if (right_step)  rec(2);
      if (left_step && right_step) overlap++;
      if (prev_lh && !left_held)  lfall = t;
      if (prev_rh && !right_held) rfall = t;
      prev_lh = left_held;
      prev_rh = right_held;
    end
  endtask

  task automatic check_seq(input string name, input int ch, input int n, input int e[8]);
    check($sformatf("%s count", name), pn[ch], n);
    for (int i = 0; i < n && i < pn[ch] && i < 8; i++)
      check($sformatf("%s time[%0d]", name, i), pt[ch][i], e[i]);
  endtask

  initial begin
    int e[8];

    // Row table: btnL held through reset release, let go after row 18.
    // Accept at row 6, repeats at 14 and 18, and 22 (level still high while
    // the release is being debounced); level falls at row 24.
    for (int i = 1; i <= 25; i++) begin
      tv[i].l   = (i <= 18);
      tv[i].exp = {1'b0, 1'b0, 1'b0, (i >= 6 && i <= 23), 1'b0};
    end
    tv[6].exp[3]  = 1'b1;
    tv[14].exp[3] = 1'b1;
    tv[18].exp[3] = 1'b1;
    tv[22].exp[3] = 1'b1;

    btnL = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      btnL = tv[i].l;
      @(negedge clk);
      check($sformatf("table row %0d", i), outs(), tv[i].exp);
    end
    run(4);

    // Bounce: 5 x (3 high, 1 low), then steady high from row 21.
    clear();
    for (int p = 0; p < 5; p++) begin
      btnL = 1'b1; run(3);
      btnL = 1'b0; run(1);
    end
    btnL = 1'b1; run(10);
    e = '{26, 0, 0, 0, 0, 0, 0, 0};
    check_seq("bounce left", 1, 1, e);
    check("bounce left_held", left_held, 1);
    check("bounce no start", pn[0], 0);
    check("bounce no right", pn[2], 0);
    btnL = 1'b0; run(12);

    // Right hold with auto-repeat; raw release lands so debounced fall is row 38.
    clear();
    btnR = 1'b1; run(32);
    btnR = 1'b0; run(12);
    e = '{6, 14, 18, 22, 26, 30, 34, 0};
    check_seq("repeat right", 2, 7, e);
    check("repeat right_held fall", rfall, 38);
    check("repeat no left", pn[1], 0);

    // Both held: silence; release left at row 21 -> left falls at 26,
    // right steps 8 cycles later.
    clear();
    btnL = 1'b1; btnR = 1'b1; run(20);
    btnL = 1'b0; run(16);
    check("conflict no left", pn[1], 0);
    e = '{34, 0, 0, 0, 0, 0, 0, 0};
    check_seq("conflict right", 2, 1, e);
    check("conflict left_held fall", lfall, 26);
    btnR = 1'b0; run(12);

    // Centre held 50 cycles: one start pulse only.
    clear();
    btnC = 1'b1; run(50);
    btnC = 1'b0; run(12);
    e = '{6, 0, 0, 0, 0, 0, 0, 0};
    check_seq("start", 0, 1, e);
    check("start no left", pn[1], 0);
    check("start no right", pn[2], 0);

    // Reset mid-repeat on left, then fresh press on deassertion.
    clear();
    btnL = 1'b1; run(20);
    e = '{6, 14, 18, 0, 0, 0, 0, 0};
    check_seq("prereset left", 1, 3, e);
    check("prereset left_held", left_held, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", outs(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in reset outputs %0d", i), outs(), 0);
    end
    rst_n = 1'b1;
    clear();
    run(16);
    e = '{6, 14, 0, 0, 0, 0, 0, 0};
    check_seq("postreset left", 1, 2, e);
    check("postreset left_held", left_held, 1);
    btnL = 1'b0; run(8);

    check("step overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
